// File: rtl/rriot_pkg.sv
// rtl/rriot_pkg.sv - shared types and helpers for the mcs6530 bus arbiter
package rriot_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    SEL_ROM = 2'b00,
    SEL_RAM = 2'b01,
    SEL_IO  = 2'b10,
    SEL_RSV = 2'b11
  } rriot_sel_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    CAPTURE = 2'b10
  } arb_state_t;

  typedef struct packed {
    logic              we_n;
    rriot_sel_t        sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } rriot_req_t;

  // ROM writes and the reserved region never strobe the slave
  function automatic logic req_legal(input rriot_req_t r);
    return !((r.sel == SEL_RSV) || ((r.sel == SEL_ROM) && !r.we_n));
  endfunction

endpackage

// File: rtl/rriot_arb_pick.sv
// rtl/rriot_arb_pick.sv - two-master winner select with an m1 starvation counter
module rriot_arb_pick
  import rriot_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic elig0_i,
  input  logic elig1_i,
  input  logic grant_en_i,
  output logic any_o,
  output logic pick_m1_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;

  always_comb begin
    any_o     = elig0_i | elig1_i;
    pick_m1_o = elig1_i & (~elig0_i | (starve_q == LIMIT));
    starve_d  = starve_q;
    if (grant_en_i && any_o) begin
      if (pick_m1_o) begin
        starve_d = '0;
      end else if (elig1_i && (starve_q != LIMIT)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/rriot_bus_arbiter.sv
// rtl/rriot_bus_arbiter.sv - shares one mcs6530 bus port between the CPU (m0) and a debug/loader port (m1)
module rriot_bus_arbiter
  import rriot_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CS1_ACT_HIGH = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we_n,
  input  logic [1:0]        m0_sel,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we_n,
  input  logic [1:0]        m1_sel,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_cs1,
  output logic              s_rs_n,
  output logic              s_we_n,
  output logic [ADDR_W-1:0] s_a,
  output logic [DATA_W-1:0] s_di,
  input  logic [DATA_W-1:0] s_do,
  output logic              busy,
  output logic              gnt_id
);

  localparam logic CS1_ON  = (CS1_ACT_HIGH != 0);
  localparam logic CS1_OFF = ~CS1_ON;

  arb_state_t        state_q, state_d;
  rriot_req_t        req_q, req_d;
  rriot_req_t        m0_bundle, m1_bundle;
  logic              gnt_q, gnt_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              cs1_q, cs1_d, rs_n_q, rs_n_d, we_n_q, we_n_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] di_q, di_d;
  logic              busy_q, busy_d;
  logic              elig0, elig1, any_elig, pick_m1;

  assign m0_bundle = '{we_n: m0_we_n, sel: rriot_sel_t'(m0_sel), addr: m0_addr, wdata: m0_wdata};
  assign m1_bundle = '{we_n: m1_we_n, sel: rriot_sel_t'(m1_sel), addr: m1_addr, wdata: m1_wdata};

  // A master's request is ignored during its own ack cycle
  assign elig0 = m0_req & ~ack0_q;
  assign elig1 = m1_req & ~ack1_q;

  rriot_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk       (clk),
    .rst_n     (rst_n),
    .elig0_i   (elig0),
    .elig1_i   (elig1),
    .grant_en_i(state_q == IDLE),
    .any_o     (any_elig),
    .pick_m1_o (pick_m1)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    gnt_d    = gnt_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    cs1_d    = CS1_OFF;
    rs_n_d   = 1'b1;
    we_n_d   = 1'b1;
    a_d      = '0;
    di_d     = '0;

    case (state_q)
      IDLE: begin
        if (any_elig) begin
          req_d   = pick_m1 ? m1_bundle : m0_bundle;
          gnt_d   = pick_m1;
          state_d = ISSUE;
          // Pins are registered here so the slave sees them throughout ISSUE
          if (req_legal(req_d)) begin
            if (req_d.sel == SEL_ROM) begin
              rs_n_d = 1'b0;
            end else begin
              cs1_d = CS1_ON;
            end
            we_n_d = req_d.we_n;
            a_d    = req_d.addr;
            di_d   = req_d.we_n ? '0 : req_d.wdata;
          end
        end
      end
      ISSUE: begin
        if (req_legal(req_q) && req_q.we_n) begin
          state_d = CAPTURE;
        end else begin
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        if (gnt_q) begin
          rdata1_d = s_do;
          ack1_d   = 1'b1;
        end else begin
          rdata0_d = s_do;
          ack0_d   = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= '0;
      gnt_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cs1_q    <= CS1_OFF;
      rs_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      a_q      <= '0;
      di_q     <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      gnt_q    <= gnt_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cs1_q    <= cs1_d;
      rs_n_q   <= rs_n_d;
      we_n_q   <= we_n_d;
      a_q      <= a_d;
      di_q     <= di_d;
      busy_q   <= busy_d;
    end
  end

  assign m0_ack   = ack0_q;
  assign m1_ack   = ack1_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
  assign s_cs1    = cs1_q;
  assign s_rs_n   = rs_n_q;
  assign s_we_n   = we_n_q;
  assign s_a      = a_q;
  assign s_di     = di_q;
  assign busy     = busy_q;
  assign gnt_id   = gnt_q;

endmodule

// File: tb/tb_rriot_bus_arbiter.sv
// tb/tb_rriot_bus_arbiter.sv - directed self-checking bench for rriot_bus_arbiter
`timescale 1ns/1ps
module tb_rriot_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_req, m0_we_n, m1_req, m1_we_n;
  logic [1:0] m0_sel, m1_sel;
  logic [9:0] m0_addr, m1_addr;
  logic [7:0] m0_wdata, m1_wdata;
  logic       m0_ack, m1_ack;
  logic [7:0] m0_rdata, m1_rdata;
  logic       s_cs1, s_rs_n, s_we_n;
  logic [9:0] s_a;
  logic [7:0] s_di;
  logic [7:0] s_do = 8'h00;
  logic       busy, gnt_id;

  int n_cmp = 0;
  int n_bad = 0;
  int strobes = 0;

  always #5 clk = ~clk;

  rriot_bus_arbiter #(
    .STARVE_LIMIT(4),
    .CS1_ACT_HIGH(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we_n(m0_we_n), .m0_sel(m0_sel), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we_n(m1_we_n), .m1_sel(m1_sel), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .s_cs1(s_cs1), .s_rs_n(s_rs_n), .s_we_n(s_we_n), .s_a(s_a), .s_di(s_di),
    .s_do(s_do), .busy(busy), .gnt_id(gnt_id)
  );

  // Slave: registered read data, ROM content is addr[7:0]^0x5C (ROM[0x010]=0x4C)
  logic [7:0] ram [0:1023];
  always @(posedge clk) begin
    if (!s_rs_n || !s_cs1) strobes <= strobes + 1;
    if (!s_rs_n && s_we_n) begin
      s_do <= s_a[7:0] ^ 8'h5C;
    end else if (!s_cs1) begin
      if (!s_we_n) ram[s_a] <= s_di;
      else         s_do <= ram[s_a];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pins_idle(input string tag);
    check_eq({tag, "_cs1"}, s_cs1, 1);
    check_eq({tag, "_rs_n"}, s_rs_n, 1);
    check_eq({tag, "_we_n"}, s_we_n, 1);
    check_eq({tag, "_a"}, s_a, 0);
    check_eq({tag, "_di"}, s_di, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int order [0:4];
  int nacks;
  int dup;
  int s0;

  initial begin
    rst_n = 1'b0;
    m0_req = 0; m0_we_n = 1; m0_sel = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we_n = 1; m1_sel = 0; m1_addr = 0; m1_wdata = 0;
    repeat (3) tick();

    check_pins_idle("rst");
    check_eq("rst_m0_ack", m0_ack, 0);
    check_eq("rst_m1_ack", m1_ack, 0);
    check_eq("rst_m0_rdata", m0_rdata, 0);
    check_eq("rst_m1_rdata", m1_rdata, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_gnt", gnt_id, 0);
    rst_n = 1'b1;
    tick();

    // m0 RAM write 0x3C5 <- 0xA5; req held through ack cycle to exercise masking
    m0_we_n = 0; m0_sel = 2'b01; m0_addr = 10'h3C5; m0_wdata = 8'hA5; m0_req = 1;
    tick();
    check_eq("wr_cs1", s_cs1, 0);
    check_eq("wr_rs_n", s_rs_n, 1);
    check_eq("wr_we_n", s_we_n, 0);
    check_eq("wr_a", s_a, 10'h3C5);
    check_eq("wr_di", s_di, 8'hA5);
    check_eq("wr_busy", busy, 1);
    check_eq("wr_gnt", gnt_id, 0);
    check_eq("wr_noack_issue", m0_ack, 0);
    tick();
    check_eq("wr_ack", m0_ack, 1);
    check_pins_idle("wr_ackcyc");
    tick();
    check_eq("wr_ack_pulse", m0_ack, 0);
    check_eq("wr_masked_busy", busy, 0);
    m0_req = 0;
    tick();

    // m0 RAM read, req dropped during ISSUE
    m0_we_n = 1; m0_sel = 2'b01; m0_addr = 10'h3C5; m0_wdata = 8'hFF; m0_req = 1;
    tick();
    check_eq("rd0_cs1", s_cs1, 0);
    check_eq("rd0_we_n", s_we_n, 1);
    check_eq("rd0_di", s_di, 0);
    m0_req = 0;
    tick();
    check_eq("rd0_cap_noack", m0_ack, 0);
    check_eq("rd0_cap_cs1", s_cs1, 1);
    check_eq("rd0_cap_busy", busy, 1);
    tick();
    check_eq("rd0_ack", m0_ack, 1);
    check_eq("rd0_rdata", m0_rdata, 8'hA5);
    tick();
    check_eq("rd0_ack_pulse", m0_ack, 0);
    check_eq("rd0_idle", busy, 0);

    // m1 ROM read 0x010
    m1_we_n = 1; m1_sel = 2'b00; m1_addr = 10'h010; m1_req = 1;
    tick();
    check_eq("rom_rs_n", s_rs_n, 0);
    check_eq("rom_cs1", s_cs1, 1);
    check_eq("rom_a", s_a, 10'h010);
    check_eq("rom_gnt", gnt_id, 1);
    tick();
    check_eq("rom_cap_noack", m1_ack, 0);
    check_eq("rom_cap_rs_n", s_rs_n, 1);
    tick();
    check_eq("rom_ack", m1_ack, 1);
    check_eq("rom_rdata", m1_rdata, 8'h4C);
    check_eq("rom_m0_rdata_kept", m0_rdata, 8'hA5);
    m1_req = 0;
    tick();

    // Illegal: m0 ROM write, then m1 reserved-region read
    s0 = strobes;
    m0_we_n = 0; m0_sel = 2'b00; m0_addr = 10'h055; m0_wdata = 8'h77; m0_req = 1;
    tick();
    check_pins_idle("ill0_issue");
    check_eq("ill0_busy", busy, 1);
    tick();
    check_eq("ill0_ack", m0_ack, 1);
    check_eq("ill0_rdata", m0_rdata, 8'hA5);
    m0_req = 0;
    m1_we_n = 1; m1_sel = 2'b11; m1_addr = 10'h123; m1_req = 1;
    tick();
    check_pins_idle("ill1_issue");
    check_eq("ill1_gnt", gnt_id, 1);
    tick();
    check_eq("ill1_ack", m1_ack, 1);
    check_eq("ill1_rdata", m1_rdata, 8'h4C);
    m1_req = 0;
    tick();
    check_eq("ill_no_strobe", strobes, s0);

    // Reset during CAPTURE of an m1 read
    m1_we_n = 1; m1_sel = 2'b01; m1_addr = 10'h3C5; m1_req = 1;
    tick();
    tick();
    check_eq("rstcap_state", busy, 1);
    rst_n = 0;
    tick();
    check_eq("rstcap_noack", m1_ack, 0);
    check_eq("rstcap_busy", busy, 0);
    check_eq("rstcap_m1_rdata", m1_rdata, 0);
    check_eq("rstcap_m0_rdata", m0_rdata, 0);
    check_eq("rstcap_gnt", gnt_id, 0);
    check_pins_idle("rstcap");
    rst_n = 1; m1_req = 0;
    tick();
    check_eq("rstcap_after_noack", m1_ack, 0);

    // Starvation: m0 holds req, m1 withdraws only in m0's ack cycles
    m0_we_n = 0; m0_sel = 2'b01; m0_addr = 10'h100; m0_wdata = 8'h11;
    m1_we_n = 0; m1_sel = 2'b10; m1_addr = 10'h200; m1_wdata = 8'h22;
    m0_req = 1; m1_req = 1;
    nacks = 0; dup = 0;
    for (int c = 0; c < 80 && nacks < 5; c++) begin
      tick();
      if (m0_ack && m1_ack) dup++;
      if (m0_ack || m1_ack) begin
        check_eq("starve_gnt_match", gnt_id, m1_ack);
        order[nacks] = m1_ack ? 1 : 0;
        nacks++;
      end
      m1_req = ~m0_ack;
    end
    m0_req = 0; m1_req = 0;
    check_eq("starve_nacks", nacks, 5);
    check_eq("starve_dup", dup, 0);
    for (int i = 0; i < 5; i++) begin
      if (i < nacks) check_eq($sformatf("starve_ord%0d", i), order[i], (i == 4) ? 1 : 0);
    end
    repeat (4) tick();
    check_eq("final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
